// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, access-size encodings, misalignment helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        ERR    = 2'b11
    } state_t;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // True when the access does not sit on its natural boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: byte enables, store-data replication, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr_lo/size/zero_ext select the lane and extension; st_data -> st_lanes,
//        ld_raw -> ld_data; be is the bus byte-enable mask.
module lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = ld_raw[7:0];
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        // Halves only look at addr[1]; an odd half address falls back to its aligned half.
        ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    always_comb begin
        be       = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_raw;
        case (size)
            SIZE_BYTE: begin
                be       = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = zero_ext ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = zero_ext ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            SIZE_WORD: begin
                be       = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_raw;
            end
            default: begin
                be       = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_raw;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Core load/store to word bus bridge with byte lanes, timeout and error reporting.
// Latency: data_ready in the 3rd cycle counting the request cycle when bus_ack comes at once.
// Backpressure: waits on bus_ack up to TIMEOUT_CYCLES; core holds its request until data_ready.
// Ports: core side data_read/data_write/data_sign/data_size/data_addr/data_write_data in,
//        data_read_data/data_ready/error out; bus side bus_req/bus_we/bus_be/bus_addr/bus_wdata
//        out, bus_rdata/bus_ack in. Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        data_sign,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_ready,
    output logic        error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [1:0]    addr_lo_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic          write_q;
    logic [CW-1:0] wait_cnt;

    logic          req_bad;
    logic [1:0]    la_addr;
    logic [1:0]    la_size;
    logic [3:0]    la_be;
    logic [31:0]   la_wdata;
    logic [31:0]   la_rdata;

    always_comb begin
        req_bad = (data_read && data_write) || (data_size == SIZE_ILLEGAL);
`ifdef MISALIGN_TRAP_EN
        req_bad = req_bad || misaligned(data_size, data_addr[1:0]);
`endif
    end

    // One aligner serves both phases: live request fields while accepting in IDLE
    // (bus lanes), latched fields afterwards (load extraction).
    always_comb begin
        la_addr = (state == IDLE) ? data_addr[1:0] : addr_lo_q;
        la_size = (state == IDLE) ? data_size      : size_q;
    end

    lane_align u_lane_align (
        .addr_lo  (la_addr),
        .size     (la_size),
        .zero_ext (sign_q),
        .st_data  (data_write_data),
        .ld_raw   (bus_rdata),
        .be       (la_be),
        .st_lanes (la_wdata),
        .ld_data  (la_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr_lo_q      <= 2'b00;
            size_q         <= SIZE_BYTE;
            sign_q         <= 1'b0;
            write_q        <= 1'b0;
            wait_cnt       <= '0;
            data_read_data <= 32'h0;
            data_ready     <= 1'b0;
            error          <= 1'b0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_be         <= 4'b0000;
            bus_addr       <= 32'h0;
            bus_wdata      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    data_ready <= 1'b0;
                    error      <= 1'b0;
                    if (data_read || data_write) begin
                        if (req_bad) begin
                            data_ready <= 1'b1;
                            error      <= 1'b1;
                            state      <= ERR;
                        end else begin
                            addr_lo_q <= data_addr[1:0];
                            size_q    <= data_size;
                            sign_q    <= data_sign;
                            write_q   <= data_write;
                            wait_cnt  <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= data_write;
                            bus_be    <= la_be;
                            bus_addr  <= {data_addr[31:2], 2'b00};
                            bus_wdata <= la_wdata;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        data_ready <= 1'b1;
                        if (!write_q) begin
                            data_read_data <= la_rdata;
                        end
                        state <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus_req    <= 1'b0;
                        data_ready <= 1'b1;
                        error      <= 1'b1;
                        state      <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    data_ready <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    data_ready <= 1'b0;
                    error      <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (TIMEOUT_CYCLES=4): vector table plus reset corner cases.
// Expected completions are queued when a request is driven and popped when data_ready rises.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_read, data_write, data_sign;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_write_data, data_read_data;
    logic        data_ready, error;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;

    always #5 clk = ~clk;

    data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .data_read(data_read), .data_write(data_write), .data_sign(data_sign),
        .data_size(data_size), .data_addr(data_addr), .data_write_data(data_write_data),
        .data_read_data(data_read_data), .data_ready(data_ready), .error(error),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    typedef struct {
        logic        rd, wr, sign;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rdata;
        int          ack_dly;      // ACCESS cycles without ack before ack; >=4 means never
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_baddr, exp_bwdata;
        logic        ld_ok;        // successful load: data_read_data takes exp_rd
        logic [31:0] exp_rd;
        int          exp_lat;      // negedges from request until data_ready seen
        int          exp_req;      // cycles bus_req is high
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          req;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[13];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic sign,
                                input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                                input logic err, input logic [3:0] be, input logic [31:0] baddr,
                                input logic [31:0] bwdata, input logic ld_ok,
                                input logic [31:0] exp_rd, input int lat, input int req);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sign = sign; v.size = size; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.ack_dly = dly; v.exp_err = err;
        v.exp_be = be; v.exp_baddr = baddr; v.exp_bwdata = bwdata; v.ld_ok = ld_ok;
        v.exp_rd = exp_rd; v.exp_lat = lat; v.exp_req = req;
        return v;
    endfunction

    task automatic idle_inputs();
        data_read = 1'b0; data_write = 1'b0; data_sign = 1'b0; data_size = 2'b00;
        data_addr = 32'h0; data_write_data = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'hA5A5_5A5A;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        int   cyc  = 0;
        int   reqn = 0;
        bit   done = 0;
        @(negedge clk);
        data_read = v.rd; data_write = v.wr; data_sign = v.sign; data_size = v.size;
        data_addr = v.addr; data_write_data = v.wdata;
        e.err = v.exp_err;
        e.rd  = v.ld_ok ? v.exp_rd : model_rd;
        e.lat = v.exp_lat;
        e.req = v.exp_req;
        sb.push_back(e);
        if (v.ld_ok) model_rd = v.exp_rd;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_req) begin
                reqn++;
                chk({name, " bus_be"},    {28'h0, bus_be}, {28'h0, v.exp_be});
                chk({name, " bus_addr"},  bus_addr,  v.exp_baddr);
                chk({name, " bus_wdata"}, bus_wdata, v.exp_bwdata);
                chk({name, " bus_we"},    {31'h0, bus_we}, {31'h0, v.wr});
                if (reqn == v.ack_dly + 1) begin
                    bus_ack = 1'b1; bus_rdata = v.rdata;
                end else begin
                    bus_ack = 1'b0; bus_rdata = 32'hA5A5_5A5A;
                end
            end else begin
                bus_ack = 1'b0; bus_rdata = 32'hA5A5_5A5A;
            end
            if (data_ready) begin
                done = 1;
                e = sb.pop_front();
                chk({name, " latency"},   32'(cyc),  32'(e.lat));
                chk({name, " req_cycles"}, 32'(reqn), 32'(e.req));
                chk({name, " error"},     {31'h0, error}, {31'h0, e.err});
                chk({name, " read_data"}, data_read_data, e.rd);
                idle_inputs();
                @(negedge clk);
                chk({name, " ready_pulse"}, {31'h0, data_ready}, 32'h0);
                chk({name, " error_pulse"}, {31'h0, error}, 32'h0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s no_completion: got none within %0d cycles, required data_ready", name, cyc);
            idle_inputs();
            sb.delete();
        end
    endtask

    initial begin
        //            rd  wr  sg  size       addr          wdata          rdata      dly err be       baddr         bwdata         ldok rd_new        lat req
        vecs[0]  = mk(1, 0, 0, SIZE_BYTE, 32'h0000_0103, 32'h0,         32'h80FF_FF7F, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,         1, 32'hFFFF_FF80, 2, 1);
        vecs[1]  = mk(0, 1, 0, SIZE_HALF, 32'h0000_0202, 32'h0000_BEEF, 32'h0,         0, 0, 4'b1100, 32'h0000_0200, 32'hBEEF_BEEF, 0, 32'h0,         2, 1);
        vecs[2]  = mk(1, 0, 1, SIZE_BYTE, 32'h0000_0101, 32'h0,         32'h1234_5678, 2, 0, 4'b0010, 32'h0000_0100, 32'h0,         1, 32'h0000_0056, 4, 3);
        vecs[3]  = mk(1, 0, 0, SIZE_HALF, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 0, 0, 4'b1100, 32'h0000_0000, 32'h0,         1, 32'hFFFF_8001, 2, 1);
        vecs[4]  = mk(1, 0, 1, SIZE_HALF, 32'h0000_0000, 32'h0,         32'h8001_F00D, 0, 0, 4'b0011, 32'h0000_0000, 32'h0,         1, 32'h0000_F00D, 2, 1);
        vecs[5]  = mk(1, 0, 0, SIZE_WORD, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF, 2, 1);
        vecs[6]  = mk(0, 1, 0, SIZE_BYTE, 32'h0000_0021, 32'h1234_56A5, 32'h0,         0, 0, 4'b0010, 32'h0000_0020, 32'hA5A5_A5A5, 0, 32'h0,         2, 1);
        vecs[7]  = mk(0, 1, 0, SIZE_WORD, 32'h0000_0030, 32'hCAFE_F00D, 32'h0,         1, 0, 4'b1111, 32'h0000_0030, 32'hCAFE_F00D, 0, 32'h0,         3, 2);
        vecs[8]  = mk(1, 0, 0, SIZE_WORD, 32'h0000_0050, 32'h0,         32'h0,       255, 1, 4'b1111, 32'h0000_0050, 32'h0,         0, 32'h0,         5, 4);
        vecs[9]  = mk(1, 1, 0, SIZE_WORD, 32'h0000_0060, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         1, 0);
        vecs[10] = mk(1, 0, 0, SIZE_ILLEGAL, 32'h0000_0070, 32'h0,      32'h0,         0, 1, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         1, 0);
`ifdef MISALIGN_TRAP_EN
        vecs[11] = mk(1, 0, 1, SIZE_HALF, 32'h0000_0101, 32'h0,         32'h7777_ABCD, 0, 1, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         1, 0);
        vecs[12] = mk(1, 0, 0, SIZE_WORD, 32'h0000_0106, 32'h0,         32'h0BAD_F00D, 0, 1, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         1, 0);
`else
        vecs[11] = mk(1, 0, 1, SIZE_HALF, 32'h0000_0101, 32'h0,         32'h7777_ABCD, 0, 0, 4'b0011, 32'h0000_0100, 32'h0,         1, 32'h0000_ABCD, 2, 1);
        vecs[12] = mk(1, 0, 0, SIZE_WORD, 32'h0000_0106, 32'h0,         32'h0BAD_F00D, 0, 0, 4'b1111, 32'h0000_0104, 32'h0,         1, 32'h0BAD_F00D, 2, 1);
`endif

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset bus_req",    {31'h0, bus_req},    32'h0);
        chk("reset bus_we",     {31'h0, bus_we},     32'h0);
        chk("reset bus_be",     {28'h0, bus_be},     32'h0);
        chk("reset bus_addr",   bus_addr,            32'h0);
        chk("reset bus_wdata",  bus_wdata,           32'h0);
        chk("reset data_ready", {31'h0, data_ready}, 32'h0);
        chk("reset error",      {31'h0, error},      32'h0);
        chk("reset read_data",  data_read_data,      32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a word load: bus_req must fall without waiting for a clock.
        @(negedge clk);
        data_read = 1'b1; data_size = SIZE_WORD; data_addr = 32'h0000_0040;
        @(negedge clk);
        chk("midrst req_before", {31'h0, bus_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst req_drop",  {31'h0, bus_req},    32'h0);
        chk("midrst no_ready",  {31'h0, data_ready}, 32'h0);
        idle_inputs();
        model_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst quiet_ready", {31'h0, data_ready}, 32'h0);
            chk("midrst quiet_req",   {31'h0, bus_req},    32'h0);
        end
        chk("midrst read_data", data_read_data, 32'h0);
        run_vec("post_rst_lw",
                mk(1, 0, 0, SIZE_WORD, 32'h0, 32'h0, 32'h1234_5678, 0, 0, 4'b1111,
                   32'h0, 32'h0, 1, 32'h1234_5678, 2, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for bus_ack before an error.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_read  input  1  core load request.
REQ-005 SHALL have port data_write  input  1  core store request.
REQ-006 SHALL have port data_sign  input  1  1 = zero-extend load, 0 = sign-extend load.
REQ-007 SHALL have port data_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port data_addr  input  32  byte address.
REQ-009 SHALL have port data_write_data  input  32  store data, right-justified.
REQ-010 SHALL have port data_read_data  output  32  formatted load result, registered.
REQ-011 SHALL have port data_ready  output  1  one-cycle pulse marking request completion.
REQ-012 SHALL have port error  output  1  one-cycle pulse, coincident with data_ready, on a failed access.
REQ-013 SHALL have ports bus_req out 1, bus_we out 1, bus_be out 4, bus_addr out 32 (word-aligned, bits [1:0]=0), bus_wdata out 32, bus_rdata in 32, bus_ack in 1.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-015 In IDLE, data_read or data_write high SHALL latch addr/size/sign/wdata and a direction flag, then go to ACCESS next cycle.
REQ-016 Both data_read and data_write high in IDLE, or data_size=11, SHALL go to ERR without bus activity.
REQ-017 Requests arriving outside IDLE SHALL be ignored; the core holds request lines until data_ready.
REQ-018 In ACCESS, bus_req SHALL be high and bus_we/bus_be/bus_addr/bus_wdata stable until the cycle bus_ack is sampled high.
REQ-019 On bus_ack in ACCESS: a load SHALL register the formatted bus_rdata into data_read_data; the FSM SHALL go to DONE.
REQ-020 DONE SHALL assert data_ready for exactly one cycle, then return to IDLE.
REQ-021 ERR SHALL assert data_ready and error for exactly one cycle, then return to IDLE; data_read_data SHALL be unchanged.
REQ-022 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack; reaching TIMEOUT_CYCLES SHALL drop bus_req and go to ERR.
REQ-023 Byte lanes: byte be=0001<<addr[1:0]; half be=0011<<(2*addr[1]); word be=1111.
REQ-024 Store data SHALL be replicated: byte into all four lanes, half into both halves, word unchanged.
REQ-025 Load formatting SHALL select the lane addressed by addr[1:0] and zero- or sign-extend it to 32 bits per data_sign.
REQ-026 Best-case latency SHALL be 3 cycles from request to data_ready when bus_ack is high in the first ACCESS cycle.
REQ-027 data_read_data SHALL hold its value until the next successful load completes.

Reset
REQ-028 rst SHALL asynchronously force IDLE, clear the wait counter, drive bus_req/bus_we/data_ready/error to 0 and bus_be/bus_addr/bus_wdata/data_read_data to 0.
REQ-029 Reset asserted during ACCESS SHALL drop bus_req immediately; no completion pulse SHALL follow.

Configuration
REQ-030 With MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=00 SHALL go to ERR without bus activity.
REQ-031 Without MISALIGN_TRAP_EN, misaligned accesses SHALL proceed: half uses addr[1] only, word ignores addr[1:0].

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum and size constants SIZE_BYTE/SIZE_HALF/SIZE_WORD.
REQ-033 Combinational sub-module lane_align SHALL compute bus_be, replicated store data and extended load data.

Verification
REQ-034 Test: LB at addr 0x103, sign=0, bus_rdata=0x80FF_FF7F, ack in first cycle -> data_read_data=0xFFFF_FF80, data_ready 3 cycles after request.
REQ-035 Test: SH addr 0x202, wdata=0x0000_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_addr=0x200, bus_we=1.
REQ-036 Test: LW with bus_ack held low and TIMEOUT_CYCLES=4 -> bus_req drops after 4 ACCESS cycles; error and data_ready pulse together.
REQ-037 Test: LHU addr 0x101 with MISALIGN_TRAP_EN -> error pulse, bus_req never high; without the macro -> bus_be=0011, access completes.
REQ-038 Test: rst asserted mid-ACCESS -> bus_req low same cycle, no data_ready; next LW to 0x0 with bus_rdata=0x1234_5678 -> data_read_data=0x1234_5678.
REQ-039 Test: data_read and data_write both high, or data_size=11 -> ERR pulse, no bus activity.
